// File: rtl/uart_rx_oversample.sv
// 8N1 UART receiver: two-flop synchronizer, oversampling tick, 3-sample mid-bit majority vote, valid/ready output register.
// Define UART_RX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_rx_oversample #(
  parameter int DIVISOR    = 27,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx_async,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 framing_err,
  output logic                 overrun,
  output logic                 parity_err
);

  localparam int TICK_W = $clog2(DIVISOR);
  localparam int SMP_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);
  localparam int MID    = OVERSAMPLE / 2;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIVISOR - 1);
  localparam logic [SMP_W-1:0]  SMP_LAST  = SMP_W'(OVERSAMPLE - 1);
  localparam logic [SMP_W-1:0]  SMP_V0    = SMP_W'(MID - 1);
  localparam logic [SMP_W-1:0]  SMP_V1    = SMP_W'(MID);
  localparam logic [SMP_W-1:0]  SMP_RES   = SMP_W'(MID + 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_t                 state;
  logic                   rx_meta_p0;
  logic                   rx_sync_p1;
  logic [TICK_W-1:0]      tick_cnt;
  logic                   tick;
  logic [SMP_W-1:0]       smp_cnt;
  logic [BIT_W-1:0]       bit_idx;
  logic                   vote_p0;
  logic                   vote_p1;
  logic                   bit_vote;
  logic                   at_res;
  logic                   at_end;
  logic                   byte_keep;
  logic [DATA_BITS-1:0]   shift_reg;

  // Stage p0/p1: metastability filter on the raw line, idle-high after reset
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
    end else begin
      rx_meta_p0 <= rx_async;
      rx_sync_p1 <= rx_meta_p0;
    end
  end

  assign tick     = (tick_cnt == TICK_LAST);
  assign at_res   = tick & (smp_cnt == SMP_RES);
  assign at_end   = tick & (smp_cnt == SMP_LAST);
  assign bit_vote = majority3(vote_p0, vote_p1, rx_sync_p1);

`ifdef UART_RX_PARITY_EN
  logic par_bad;
  assign byte_keep = ~par_bad;
`else
  assign byte_keep  = 1'b1;
  assign parity_err = 1'b0;
`endif

  // Vote capture and LSB-first reconstruction; pure datapath, no reset
  always_ff @(posedge clock) begin
    if (tick && smp_cnt == SMP_V0) vote_p0 <= rx_sync_p1;
    if (tick && smp_cnt == SMP_V1) vote_p1 <= rx_sync_p1;
    if (state == ST_DATA && at_res) shift_reg <= {bit_vote, shift_reg[DATA_BITS-1:1]};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      tick_cnt    <= '0;
      smp_cnt     <= '0;
      bit_idx     <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err  <= 1'b0;
      par_bad     <= 1'b0;
`endif
    end else begin
      framing_err <= 1'b0;
      overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err  <= 1'b0;
`endif
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (tick) smp_cnt <= (smp_cnt == SMP_LAST) ? '0 : smp_cnt + 1'b1;
      // A completing byte below overrides this consume
      if (data_valid && data_ready) data_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          smp_cnt <= '0;
          if (!rx_sync_p1) begin
            state    <= ST_START;
            tick_cnt <= '0;
          end
        end
        ST_START: begin
          if (at_res && bit_vote) begin
            state <= ST_IDLE;
          end else if (at_end) begin
            state   <= ST_DATA;
            bit_idx <= '0;
          end
        end
        ST_DATA: begin
          if (at_end) begin
            if (bit_idx == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (at_res) begin
            par_bad    <= (bit_vote != ^shift_reg);
            parity_err <= (bit_vote != ^shift_reg);
          end
          if (at_end) state <= ST_STOP;
        end
`endif
        ST_STOP: begin
          if (at_res) begin
            state <= ST_IDLE;
            if (!bit_vote) begin
              framing_err <= 1'b1;
            end else if (byte_keep) begin
              if (!data_valid || data_ready) begin
                data_out   <= shift_reg;
                data_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Randomized frame-level bench for uart_rx_oversample with a byte/output-register reference model.
module tb_uart_rx_oversample;

  localparam int DIVISOR    = 4;
  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;
  localparam int BIT_CLKS   = DIVISOR * OVERSAMPLE;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int NBITS = 2 + DATA_BITS + PAR_BITS;
  // Line fall -> 2 sync clocks + detecting edge, then bits up to stop, then vote resolved at tick s=M+1
  localparam int DONE_OFS = 3 + (1 + DATA_BITS + PAR_BITS) * BIT_CLKS + (OVERSAMPLE / 2 + 2) * DIVISOR;

  logic                 clock;
  logic                 reset;
  logic                 rx_async;
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 data_ready;
  logic                 framing_err;
  logic                 overrun;
  logic                 parity_err;

  int n_checks;
  int n_fail;
  int fe_cnt;
  int ov_cnt;
  int pe_cnt;

  logic                 m_valid;
  logic [DATA_BITS-1:0] m_data;

  uart_rx_oversample #(
    .DIVISOR    (DIVISOR),
    .OVERSAMPLE (OVERSAMPLE),
    .DATA_BITS  (DATA_BITS)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .rx_async    (rx_async),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .framing_err (framing_err),
    .overrun     (overrun),
    .parity_err  (parity_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (framing_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (parity_err) pe_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      rx_async = 1'b1;
    end
  endtask

  task automatic consume();
    @(negedge clock);
    data_ready = 1'b1;
    @(negedge clock);
    data_ready = 1'b0;
    m_valid = 1'b0;
    check_eq("consume_valid", 32'(data_valid), 32'(m_valid));
    check_eq("consume_data", 32'(data_out), 32'(m_data));
  endtask

  // gofs < 0: clean frame; otherwise invert each data bit for DIVISOR-1 clocks from offset gofs
  task automatic send_frame(input string tag, input logic [DATA_BITS-1:0] data, input logic stop_bit,
                            input logic par_bit, input int gofs, input logic rdy_at_done);
    logic bitv [0:NBITS-1];
    logic old_valid;
    logic fe_exp;
    logic pe_exp;
    logic ov_exp;
    int   fe0;
    int   ov0;
    int   pe0;
    int   bi;
    int   off;

    bitv[0] = 1'b0;
    for (int i = 0; i < DATA_BITS; i++) bitv[1+i] = data[i];
    if (PAR_BITS != 0) bitv[1+DATA_BITS] = par_bit;
    bitv[NBITS-1] = stop_bit;

    old_valid = m_valid;
    fe_exp = ~stop_bit;
    pe_exp = (PAR_BITS != 0) && (par_bit != ^data);
    ov_exp = 1'b0;
    if (!fe_exp && !pe_exp) begin
      if (!m_valid || rdy_at_done) begin
        m_data  = data;
        m_valid = 1'b1;
      end else begin
        ov_exp = 1'b1;
      end
    end else if (m_valid && rdy_at_done) begin
      m_valid = 1'b0;
    end

    fe0 = fe_cnt;
    ov0 = ov_cnt;
    pe0 = pe_cnt;
    for (int k = 0; k < NBITS * BIT_CLKS; k++) begin
      @(negedge clock);
      bi  = k / BIT_CLKS;
      off = k % BIT_CLKS;
      rx_async = bitv[bi];
      if (gofs >= 0 && bi >= 1 && bi <= DATA_BITS && off >= gofs && off < gofs + DIVISOR - 1)
        rx_async = ~bitv[bi];
      if (k == DONE_OFS - 1) begin
        check_eq({tag, "_pre_valid"}, 32'(data_valid), 32'(old_valid));
        data_ready = rdy_at_done;
      end
      if (k == DONE_OFS) begin
        data_ready = 1'b0;
        check_eq({tag, "_valid"}, 32'(data_valid), 32'(m_valid));
        check_eq({tag, "_data"}, 32'(data_out), 32'(m_data));
        check_eq({tag, "_ferr"}, 32'(framing_err), 32'(fe_exp));
        check_eq({tag, "_ovr"}, 32'(overrun), 32'(ov_exp));
      end
    end
    rx_async = 1'b1;
    check_eq({tag, "_ferr_cnt"}, fe_cnt - fe0, 32'(fe_exp));
    check_eq({tag, "_ovr_cnt"}, ov_cnt - ov0, 32'(ov_exp));
    check_eq({tag, "_perr_cnt"}, pe_cnt - pe0, 32'(pe_exp));
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DATA_BITS-1:0] d;
    logic                 stop;
    logic                 rdy;
    logic                 par;
    int                   gofs;
    int                   fe0;
    int                   ov0;
    int                   pe0;

    n_checks   = 0;
    n_fail     = 0;
    fe_cnt     = 0;
    ov_cnt     = 0;
    pe_cnt     = 0;
    m_valid    = 1'b0;
    m_data     = '0;
    reset      = 1'b1;
    rx_async   = 1'b1;
    data_ready = 1'b0;

    repeat (4) @(negedge clock);
    check_eq("rst_valid", 32'(data_valid), 32'd0);
    check_eq("rst_data", 32'(data_out), 32'd0);
    check_eq("rst_ferr", 32'(framing_err), 32'd0);
    check_eq("rst_ovr", 32'(overrun), 32'd0);
    check_eq("rst_perr", 32'(parity_err), 32'd0);
    reset = 1'b0;
    idle(2 * BIT_CLKS);

    // Receive and hold, then one-cycle consume
    send_frame("a5", 8'hA5, 1'b1, ^8'hA5, -1, 1'b0);
    idle(3 * BIT_CLKS);
    check_eq("a5_held_valid", 32'(data_valid), 32'd1);
    check_eq("a5_held_data", 32'(data_out), 32'hA5);
    consume();

    // False start: short low pulse, then a real frame
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    pe0 = pe_cnt;
    for (int i = 0; i < 3 * DIVISOR; i++) begin
      @(negedge clock);
      rx_async = 1'b0;
    end
    idle(2 * BIT_CLKS);
    check_eq("fstart_valid", 32'(data_valid), 32'd0);
    check_eq("fstart_ferr_cnt", fe_cnt - fe0, 32'd0);
    check_eq("fstart_ovr_cnt", ov_cnt - ov0, 32'd0);
    check_eq("fstart_perr_cnt", pe_cnt - pe0, 32'd0);
    send_frame("5a", 8'h5A, 1'b1, ^8'h5A, -1, 1'b0);
    idle(BIT_CLKS);
    consume();

    // Framing error
    send_frame("3c_ferr", 8'h3C, 1'b0, ^8'h3C, -1, 1'b0);
    idle(2 * BIT_CLKS);

    // Back-to-back overrun, then back-to-back with ready at completion
    send_frame("11", 8'h11, 1'b1, ^8'h11, -1, 1'b0);
    send_frame("22_ovr", 8'h22, 1'b1, ^8'h22, -1, 1'b0);
    idle(BIT_CLKS);
    consume();
    send_frame("11b", 8'h11, 1'b1, ^8'h11, -1, 1'b0);
    send_frame("22_rdy", 8'h22, 1'b1, ^8'h22, -1, 1'b1);
    idle(BIT_CLKS);
    consume();

    // One corrupted vote per data bit, then reset mid-frame
    send_frame("ff_glitch", 8'hFF, 1'b1, ^8'hFF, (OVERSAMPLE / 2) * DIVISOR, 1'b0);
    idle(BIT_CLKS);
    for (int k = 0; k < 5 * BIT_CLKS + BIT_CLKS / 2; k++) begin
      @(negedge clock);
      rx_async = (k < BIT_CLKS) ? 1'b0 : 1'b1;
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    m_valid = 1'b0;
    m_data  = '0;
    check_eq("midrst_valid", 32'(data_valid), 32'd0);
    check_eq("midrst_data", 32'(data_out), 32'd0);
    check_eq("midrst_ferr", 32'(framing_err), 32'd0);
    check_eq("midrst_ovr", 32'(overrun), 32'd0);
    idle(2 * BIT_CLKS);
    send_frame("81", 8'h81, 1'b1, ^8'h81, -1, 1'b0);
    idle(BIT_CLKS);
    consume();

`ifdef UART_RX_PARITY_EN
    send_frame("07_badpar", 8'h07, 1'b1, 1'b0, -1, 1'b0);
    idle(2 * BIT_CLKS);
    send_frame("07_goodpar", 8'h07, 1'b1, 1'b1, -1, 1'b0);
    idle(BIT_CLKS);
    consume();
`endif

    for (int f = 0; f < 16; f++) begin
      d    = DATA_BITS'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      rdy  = 1'($urandom_range(0, 1));
      par  = (^d) ^ ($urandom_range(0, 4) == 0);
      gofs = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, BIT_CLKS - DIVISOR)) : -1;
      send_frame($sformatf("rnd%0d", f), d, stop, par, gofs, rdy);
      if (stop) idle(int'($urandom_range(1, 8 * DIVISOR)));
      else idle(2 * BIT_CLKS);
      if ($urandom_range(0, 1) != 0) consume();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
